oled_spi_rx: RTL

Display-side receiver for the processor's OLED serial link: it reassembles the `oled_sclk`/`oled_sdin` bit stream into bytes and tags each byte as command or data from `oled_dc`. It also tracks the reset and power rails. Captured bytes are buffered in a small FIFO with a valid/ready drain port. It sits beside the processor in simulation and loopback builds, so the bench and on-chip checkers can read back exactly what the processor sent to the panel.

---
 rtl/oled_pkg.sv | 17 +
 rtl/oled_rx_fifo.sv | 57 +++++
 rtl/oled_spi_rx.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared constants and byte payload type for the OLED serial receiver.
package oled_pkg;

   localparam logic DC_CMD     = 1'b0;
   localparam logic DC_DATA    = 1'b1;
   localparam logic RAIL_ON    = 1'b0;
   localparam logic RES_ACTIVE = 1'b0;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned COUNT_W = 16;

   typedef struct packed {
      logic              is_data;
      logic [BYTE_W-1:0] value;
   } oled_byte_t;

endpackage

// File: rtl/oled_rx_fifo.sv
// Synchronous FIFO of tagged bytes; a push into a full FIFO is accepted
// only when a pop happens in the same cycle, otherwise it is dropped.
module oled_rx_fifo
   import oled_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  oled_byte_t push_data,
   input  logic       pop_ready,
   output logic       valid,
   output oled_byte_t head,
   output logic       accept_c,
   output logic       overflow_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   oled_byte_t    mem [DEPTH];
   logic          empty;
   logic          full;
   logic          pop;

   // Pointer MSB separates full from empty when the index bits match.
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = pop_ready && !empty;
   assign accept_c   = push && (!full || pop);
   assign overflow_c = push && full && !pop;
   assign valid      = !empty;
   assign head       = mem[rd_ptr[AW-1:0]];

   // Storage and pointers; storage is cleared so the head reads zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (accept_c) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

endmodule

// File: rtl/oled_spi_rx.sv
// Display-side receiver for the OLED serial link: rebuilds bytes from
// sclk/sdin, tags them with dc, tracks the rails and buffers into a FIFO.
module oled_spi_rx
   import oled_pkg::*;
#(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned IDLE_CYCLES = 64
) (
   input  logic               sysclk,
   input  logic               rst,
   input  logic               oled_sclk,
   input  logic               oled_sdin,
   input  logic               oled_dc,
   input  logic               oled_res,
   input  logic               oled_vdd,
   input  logic               oled_vbat,
   output logic               rx_valid,
   input  logic               rx_ready,
   output logic [BYTE_W-1:0]  rx_byte,
   output logic               rx_is_data,
   output logic [COUNT_W-1:0] cmd_count,
   output logic [COUNT_W-1:0] data_count,
   output logic               overflow,
   output logic               err_nopower,
   output logic               panel_on
);

   localparam int unsigned SYNC_W = 6;
   localparam int unsigned I_SCLK = 0;
   localparam int unsigned I_SDIN = 1;
   localparam int unsigned I_DC   = 2;
   localparam int unsigned I_RES  = 3;
   localparam int unsigned I_VDD  = 4;
   localparam int unsigned I_VBAT = 5;
   // vbat/vdd off, res asserted, sclk/sdin/dc low
   localparam logic [SYNC_W-1:0] SYNC_RST = 6'b11_0000;
   localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);

   logic [SYNC_W-1:0] sync1;
   logic [SYNC_W-1:0] sync2;
   logic              sclk_prev;
   logic [7:0]        shreg;
   logic [2:0]        bitcnt;
   logic [IDLE_W-1:0] idle_cnt;
   logic              byte_vld;
   oled_byte_t        byte_q;
   logic              sclk_rise_c;
   logic              res_active_c;
   logic              byte_done_c;
   logic              accept_c;
   logic              overflow_c;
   oled_byte_t        head;

   assign sclk_rise_c  = sync2[I_SCLK] && !sclk_prev;
   assign res_active_c = (sync2[I_RES] == RES_ACTIVE);
   assign byte_done_c  = sclk_rise_c && (bitcnt == 3'd7) && !res_active_c;
   assign panel_on     = (sync2[I_VDD] == RAIL_ON) && (sync2[I_VBAT] == RAIL_ON) && !res_active_c;

   // Two-flop synchronizers for every panel-side input.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         sync1 <= SYNC_RST;
         sync2 <= SYNC_RST;
      end else begin
         sync1 <= {oled_vbat, oled_vdd, oled_res, oled_dc, oled_sdin, oled_sclk};
         sync2 <= sync1;
      end
   end

   // Shift register, bit counter, idle timeout and completed-byte register.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         sclk_prev <= 1'b0;
         shreg     <= '0;
         bitcnt    <= '0;
         idle_cnt  <= '0;
         byte_vld  <= 1'b0;
         byte_q    <= '0;
      end else begin
         sclk_prev <= sync2[I_SCLK];
         byte_vld  <= 1'b0;
         if (res_active_c) begin
            shreg    <= '0;
            bitcnt   <= '0;
            idle_cnt <= '0;
         end else if (sclk_rise_c) begin
            idle_cnt <= '0;
            shreg    <= {shreg[6:0], sync2[I_SDIN]};
            bitcnt   <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
               byte_vld       <= 1'b1;
               byte_q.is_data <= sync2[I_DC];
               byte_q.value   <= {shreg[6:0], sync2[I_SDIN]};
            end
         end else if (idle_cnt == IDLE_W'(IDLE_CYCLES)) begin
            shreg  <= '0;
            bitcnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
         end
      end
   end

   // Accepted-byte counters and sticky error flags.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         cmd_count   <= '0;
         data_count  <= '0;
         overflow    <= 1'b0;
         err_nopower <= 1'b0;
      end else begin
         if (accept_c) begin
            if (byte_q.is_data == DC_DATA) begin
               data_count <= data_count + COUNT_W'(1);
            end else begin
               cmd_count <= cmd_count + COUNT_W'(1);
            end
         end
         if (overflow_c) begin
            overflow <= 1'b1;
         end
         if (byte_done_c && !panel_on) begin
            err_nopower <= 1'b1;
         end
      end
   end

   oled_rx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (sysclk),
      .rst        (rst),
      .push       (byte_vld),
      .push_data  (byte_q),
      .pop_ready  (rx_ready),
      .valid      (rx_valid),
      .head       (head),
      .accept_c   (accept_c),
      .overflow_c (overflow_c)
   );

   assign rx_byte    = head.value;
   assign rx_is_data = head.is_data;

endmodule
